// File: rtl/serial_nma_ctrl.sv
// serial_nma_ctrl
//
// Computes {co, s} = a + b + ci for N-bit operands. A single shared 2-bit
// digit adder is reused once per clock, so the sum is built one digit per
// cycle, least significant digit first. The carry between digits is held in
// a register from one cycle to the next.
//
// Parameters
//   N      operand width in bits. Must be even and at least 2.
//          The digit count is D = N/2.
//
// Ports
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  request. Only sampled while idle.
//   a, b   operands. Captured on an accepted start.
//   ci     carry-in. Captured on an accepted start.
//   busy   high while digits are being processed
//   done   one-cycle pulse on the edge that updates s and co
//   s      registered sum. Holds the last result.
//   co     registered carry-out. Holds the last result.

module serial_nma_ctrl #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] s,
  output logic         co
);

  localparam int D  = N / 2;
  localparam int IW = (D > 1) ? $clog2(D) : 1;
  localparam logic [IW-1:0] LAST = IW'(D - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [IW-1:0] idx;
  logic [N-1:0]  a_r;
  logic [N-1:0]  b_r;
  logic          c_r;
  logic [N-1:0]  acc;

  logic [IW:0]   shamt;
  logic [1:0]    a_dig;
  logic [1:0]    b_dig;
  logic [2:0]    dsum;
  logic [1:0]    dig;
  logic          cout;
  logic          last;
  logic [N-1:0]  acc_nxt;

  // The digit slice. The current digit of each operand is selected by
  // shifting the operand right by 2*idx. A shift keeps the selection legal
  // for every N, including N=2, where idx is a single bit that stays at 0.
  // The next accumulator value is the current accumulator with the new digit
  // written into its slot. On the last digit this is the complete sum,
  // because acc is cleared at start and the upper digits are still zero.
  always_comb begin
    shamt   = {idx, 1'b0};
    a_dig   = 2'(a_r >> shamt);
    b_dig   = 2'(b_r >> shamt);
    dsum    = {1'b0, a_dig} + {1'b0, b_dig} + {2'b00, c_r};
    dig     = dsum[1:0];
    cout    = dsum[2];
    last    = (idx == LAST);
    acc_nxt = (acc & ~(N'(3) << shamt)) | (N'(dig) << shamt);
  end

  // State register for the IDLE/RUN controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic. A start request is only honoured in IDLE. Once in RUN,
  // the controller returns to IDLE right after the last digit. This makes
  // the done cycle an IDLE cycle, so a new request can be accepted then.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (last)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath registers.
  // On an accepted start, the operands and carry-in are latched, and the
  // digit index and accumulator are cleared.
  // In RUN, each edge stores one digit and carries into the next digit.
  // Only the final digit edge touches s/co, so partial sums never appear on
  // the outputs. done is cleared on every other edge, which makes it a
  // single-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx  <= '0;
      a_r  <= '0;
      b_r  <= '0;
      c_r  <= 1'b0;
      acc  <= '0;
      s    <= '0;
      co   <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r <= a;
            b_r <= b;
            c_r <= ci;
            idx <= '0;
            acc <= '0;
          end
        end
        RUN: begin
          acc <= acc_nxt;
          c_r <= cout;
          if (last) begin
            s    <= acc_nxt;
            co   <= cout;
            done <= 1'b1;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // busy is decoded straight from the state register, so it does not glitch.
  assign busy = (state == RUN);

endmodule

// File: doc/serial_nma_ctrl.md
# serial_nma_ctrl

Sequential controller that computes an N-bit binary add, a + b + ci, one 2-bit digit per clock through a single shared 2-bit digit-add slice. It replaces the fully unrolled N/2-slice ripple adder wherever area matters more than latency. It accepts operands on a start pulse, walks the digits LSB-first with a registered inter-digit carry, and presents the full sum and carry-out with a one-cycle done pulse.

## Interface
Parameters:
- N, default 8: operand width in bits; must be even and ≥ 2; digit count D = N/2.

Ports:
- clk  in  1  rising-edge clock; the block's only clock.
- rst_n  in  1  reset, asynchronous and active-low.
- start  in  1  request; sampled only in IDLE.
- a  in  N  operand A; captured on an accepted start.
- b  in  N  operand B; captured on an accepted start.
- ci  in  1  carry-in; captured on an accepted start.
- busy  out  1  high while in RUN.
- done  out  1  one-cycle pulse when s/co are updated.
- s  out  N  sum, registered; holds the last result.
- co  out  1  carry-out, registered; holds the last result.

## Operation
- Internal state:
  - FSM states: IDLE and RUN.
  - Digit index idx is ceil(log2 D) bits wide, minimum 1 bit.
  - Operand registers A_r and B_r.
  - Carry register c_r.
  - Accumulator acc, N bits wide.
- Digit slice is combinational and plain binary: {cout, d[1:0]} = A_r[2i+1:2i] + B_r[2i+1:2i] + c_r, with i = idx.
- IDLE, start=1:
  - A_r←a, B_r←b, c_r←ci, idx←0, acc←0.
  - Go to RUN.
- IDLE, start=0: hold all state.
- RUN, every edge:
  - acc[2idx+1:2idx]←d, c_r←cout.
  - If idx < D−1: idx←idx+1.
  - If idx == D−1: s←{d, acc[2idx−1:0]} (for N=2, s←d), co←cout, done←1, go to IDLE.
- done is high for exactly one cycle. It is cleared on the next edge.
- start is ignored while in RUN. No queueing.
- Operand inputs a, b and ci are don't-care except at the accepting edge.
- Result is mathematically {co, s} = a + b + ci. Width is N+1 bits with no overflow loss.

## Timing
- Reset values, applied immediately on rst_n low:
  - state=IDLE, busy=0, done=0, s=0, co=0.
  - idx=0, c_r=0, acc=0, A_r=0, B_r=0.
- Reset mid-RUN: the operation is abandoned. No done is produced. s and co read 0. After rst_n deasserts, the block waits for a fresh start.
- Latency:
  - start is accepted at edge k.
  - busy=1 after edge k.
  - Digits are processed at edges k+1 … k+D.
  - s, co and done are updated at edge k+D, where busy drops.
  - For N=8 this is 4 cycles; for N=2 it is 1 cycle.
- Throughput:
  - done and IDLE coincide, so start high in the done cycle is accepted at edge k+D+1.
  - Back-to-back issue therefore gives one result per D+1 cycles.
- s and co change only on done edges. They never show partial sums.
- busy = (state == RUN), decoded from the state register. It is glitch-free.

## Test plan
- Reset, then N=8, a=0x80, b=0x01, ci=1, one-cycle start → busy high for 4 cycles; done pulses once, 4 cycles after the start edge; s=0x82, co=0.
- a=0x80, b=0x80, ci=0 → s=0x00, co=1; earlier s/co held until this done edge.
- a=0xFF, b=0x00, ci=1 (carry ripples through all 4 digits) → s=0x00, co=1; a=0x00, b=0x00, ci=0 → s=0x00, co=0.
- Start with a=0x12, b=0x34; pulse start again mid-RUN with a=0xFF → second pulse ignored; single done; s=0x46, co=0.
- Deassert rst_n at cycle 2 of a RUN → busy=0, done=0, s=0, co=0 immediately; no done after release; a new start completes normally.
- Hold start high continuously with a fixed operand pair → done every 5 cycles; busy low exactly one cycle between runs; N=2 build: a=3, b=3, ci=1 → s=3, co=1 after 1 cycle.
